seg_scan_ctrl: RTL



---
 rtl/seg_pkg.sv | 20 ++
 rtl/seg_scan_ctrl_hex2seg.sv | 33 +++
 rtl/seg_scan_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: digit count,
// select width, blank pattern and the active-low hex segment table.
package seg_pkg;

    localparam int unsigned DIGITS = 8;
    localparam int unsigned SEL_W  = 3;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [6:0]       seg_t;

    // Segment order is {g,f,e,d,c,b,a}, active low
    localparam seg_t SEG_BLANK = 7'h7F;

    // Entry k is the pattern for hex digit k (index 15 listed first)
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg_scan_ctrl_hex2seg.sv
// hex2seg: 4-bit hex digit to active-low seven-segment pattern.
module hex2seg
    import seg_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg_n
);

    // Combinational lookup of the segment pattern for one nibble
    always_comb begin
        o_seg_n = SEG_BLANK;
        case (i_hex)
            4'h0: o_seg_n = HEX_SEG[0];
            4'h1: o_seg_n = HEX_SEG[1];
            4'h2: o_seg_n = HEX_SEG[2];
            4'h3: o_seg_n = HEX_SEG[3];
            4'h4: o_seg_n = HEX_SEG[4];
            4'h5: o_seg_n = HEX_SEG[5];
            4'h6: o_seg_n = HEX_SEG[6];
            4'h7: o_seg_n = HEX_SEG[7];
            4'h8: o_seg_n = HEX_SEG[8];
            4'h9: o_seg_n = HEX_SEG[9];
            4'hA: o_seg_n = HEX_SEG[10];
            4'hB: o_seg_n = HEX_SEG[11];
            4'hC: o_seg_n = HEX_SEG[12];
            4'hD: o_seg_n = HEX_SEG[13];
            4'hE: o_seg_n = HEX_SEG[14];
            4'hF: o_seg_n = HEX_SEG[15];
            default: o_seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an 8-digit
// seven-segment display. Optional leading-zero blanking is enabled by
// defining SEG_LZ_BLANK_EN.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned CNT_W    = 20
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  en_in,
    output logic [2:0]  sel,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame
);

    logic [CNT_W-1:0] r_presc;
    sel_t             r_sel;
    logic [31:0]      r_data;
    logic [7:0]       r_dp;
    logic [7:0]       r_en;
    seg_t             r_seg_n;
    logic             r_dp_n;
    logic             r_frame;

    logic             w_tick;
    sel_t             w_sel_nxt;
    logic [31:0]      w_data_nxt;
    logic [7:0]       w_dp_nxt;
    logic [7:0]       w_en_nxt;
    logic [7:0]       w_en_eff;
    logic [3:0]       w_nib;
    seg_t             w_hex_seg;

    assign w_tick     = (r_presc == CNT_W'(SCAN_DIV - 1));
    assign w_sel_nxt  = w_tick ? r_sel + SEL_W'(1) : r_sel;
    assign w_data_nxt = load ? data_in : r_data;
    assign w_dp_nxt   = load ? dp_in   : r_dp;
    assign w_en_nxt   = load ? en_in   : r_en;
    assign w_nib      = w_data_nxt[{w_sel_nxt, 2'b00} +: 4];

    // Effective digit enable, optionally suppressing leading zeros
    always_comb begin
        w_en_eff = w_en_nxt;
`ifdef SEG_LZ_BLANK_EN
        for (int unsigned k = 1; k < DIGITS; k++) begin
            w_en_eff[k] = w_en_nxt[k] & (|(w_data_nxt >> (4 * k)));
        end
`endif
    end

    hex2seg u_hex2seg (
        .i_hex   (w_nib),
        .o_seg_n (w_hex_seg)
    );

    // Prescaler, digit index, capture registers and registered outputs;
    // outputs are built from next-state values so sel and seg change together
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_presc <= '0;
            r_sel   <= '0;
            r_data  <= '0;
            r_dp    <= '0;
            r_en    <= '1;
            r_seg_n <= SEG_BLANK;
            r_dp_n  <= 1'b1;
            r_frame <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + CNT_W'(1);
            r_sel   <= w_sel_nxt;
            r_frame <= w_tick && (r_sel == SEL_W'(DIGITS - 1));
            r_data  <= w_data_nxt;
            r_dp    <= w_dp_nxt;
            r_en    <= w_en_nxt;
            r_seg_n <= w_en_eff[w_sel_nxt] ? w_hex_seg : SEG_BLANK;
            r_dp_n  <= ~(w_dp_nxt[w_sel_nxt] & w_en_eff[w_sel_nxt]);
        end
    end

    assign sel   = r_sel;
    assign seg_n = r_seg_n;
    assign dp_n  = r_dp_n;
    assign frame = r_frame;

endmodule
